// File: rtl/core_pkg.sv
// Shared core types and ALU encodings used by the ALU/memory arbiter and its users.
package core_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_FUNC_W = 4;

  localparam logic ALU_MODE_ARITH = 1'b0;
  localparam logic ALU_MODE_LOGIC = 1'b1;

  localparam logic [ALU_FUNC_W-1:0] ALU_LOGIC_XOR = 4'h9;
  localparam logic [ALU_FUNC_W-1:0] ALU_ARITH_INC = 4'hF;

  localparam logic ALU_CARRY_NONE = 1'b0;
  localparam logic ALU_CARRY_SET  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_DATA = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_E = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  mem;
    logic                  mode;
    logic [ALU_FUNC_W-1:0] func;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic                  cn;
  } alu_op_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Fetch/exec priority decision: exec wins unless fetch has lost MAX_WAIT arbitrations in a row.
module arb_prio_sel
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    arb_en,
  input  logic    f_req,
  input  logic    e_req,
  output req_id_t winner
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_r;

  // Winner for the current arbitration cycle
  always_comb begin
    if (e_req && !(f_req && (wait_cnt_r == WAIT_SAT))) begin
      winner = REQ_E;
    end else begin
      winner = REQ_F;
    end
  end

  // Lost-arbitration counter, stepped once per arbitration rather than per cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_r <= '0;
    end else if (arb_en) begin
      if (winner == REQ_F) begin
        wait_cnt_r <= '0;
      end else if (f_req && (wait_cnt_r != WAIT_SAT)) begin
        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

endmodule

// File: rtl/alu_mem_arbiter.sv
// Shares the single ALU and memory read port between fetch (F) and decode/exec (E),
// returning registered results with a one-cycle done pulse to the owner.
module alu_mem_arbiter
  import core_pkg::*;
#(
  parameter int DATA_W   = ALU_DATA_W,
  parameter int FUNC_W   = ALU_FUNC_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_req,
  input  logic              f_mem,
  input  logic              f_mode,
  input  logic [FUNC_W-1:0] f_func,
  input  logic [DATA_W-1:0] f_a,
  input  logic [DATA_W-1:0] f_b,
  input  logic              f_cn,
  input  logic              e_req,
  input  logic              e_mem,
  input  logic              e_mode,
  input  logic [FUNC_W-1:0] e_func,
  input  logic [DATA_W-1:0] e_a,
  input  logic [DATA_W-1:0] e_b,
  input  logic              e_cn,
  output logic              f_gnt,
  output logic              f_done,
  output logic              e_gnt,
  output logic              e_done,
  output logic [DATA_W-1:0] res_f,
  output logic              res_zf,
  output logic [DATA_W-1:0] res_mdata,
  output logic              alu_mode,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cn,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zf,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_r;
  req_id_t    owner_r;
  req_id_t    winner_s;
  req_id_t    sel_s;
  logic       mem_r;
  logic       arb_en_s;
  alu_op_t    f_op_s;
  alu_op_t    e_op_s;
  alu_op_t    op_s;

  assign arb_en_s = (state_r == IDLE) && (f_req || e_req);

  arb_prio_sel #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .CLK    (CLK),
    .RST    (RST),
    .arb_en (arb_en_s),
    .f_req  (f_req),
    .e_req  (e_req),
    .winner (winner_s)
  );

  // Operand mux: the arbitration winner while idle, the latched owner afterwards
  always_comb begin
    f_op_s = '{mem: f_mem, mode: f_mode, func: f_func, a: f_a, b: f_b, cn: f_cn};
    e_op_s = '{mem: e_mem, mode: e_mode, func: e_func, a: e_a, b: e_b, cn: e_cn};
    if (state_r == IDLE) begin
      sel_s = winner_s;
    end else begin
      sel_s = owner_r;
    end
    if (sel_s == REQ_E) begin
      op_s = e_op_s;
    end else begin
      op_s = f_op_s;
    end
  end

  // ALU/memory drive, held at zero outside EXEC so idle buses never float
  always_comb begin
    if (state_r == EXEC) begin
      alu_mode = op_s.mode;
      alu_func = op_s.func;
      alu_a    = op_s.a;
      alu_b    = op_s.b;
      alu_cn   = op_s.cn;
      mem_rd   = mem_r;
    end else begin
      alu_mode = 1'b0;
      alu_func = '0;
      alu_a    = '0;
      alu_b    = '0;
      alu_cn   = 1'b0;
      mem_rd   = 1'b0;
    end
    if (mem_rd) begin
      mem_addr = op_s.a;
    end else begin
      mem_addr = '0;
    end
  end

  // Grant/done decoded from registered state and owner only
  always_comb begin
    f_gnt  = (state_r != IDLE) && (owner_r == REQ_F);
    e_gnt  = (state_r != IDLE) && (owner_r == REQ_E);
    f_done = (state_r == DONE) && (owner_r == REQ_F);
    e_done = (state_r == DONE) && (owner_r == REQ_E);
  end

  // Sequencer, owner latch and result capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      owner_r   <= REQ_F;
      mem_r     <= 1'b0;
      res_f     <= '0;
      res_zf    <= 1'b0;
      res_mdata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (f_req || e_req) begin
            owner_r <= winner_s;
            mem_r   <= op_s.mem;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_f  <= alu_f;
          res_zf <= alu_zf;
          if (mem_r) begin
            state_r <= MEM_DATA;
          end else begin
            state_r <= DONE;
          end
        end
        MEM_DATA: begin
          res_mdata <= mem_rdata;
          state_r   <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
